cbs_window_feeder: RTL and testbench

Streaming line-buffer front end for the CBS convolution stage. Accepts raster-order 8-bit pixels over a valid/ready stream and assembles 3-row x 10-pixel windows, stride 8, in exactly the 240-bit packing the CBS 3x3 convolution block consumes. Emits one window per 8 output columns over a valid/ready handshake. It is the producer end of the CBS `img` interface.

---
 rtl/cbs_pkg.sv | 26 ++
 rtl/cbs_line_bank.sv | 37 +++
 rtl/cbs_window_feeder.sv | 134 +++++++++++++
 tb/tb_cbs_window_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cbs_pkg.sv
// Shared constants, FSM state type and bank-pointer helpers for the CBS window feeder.
package cbs_pkg;

  localparam int PIX_W      = 8;
  localparam int WIN_ROWS   = 3;
  localparam int WIN_COLS   = 10;
  localparam int WIN_STRIDE = 8;
  localparam int WIN_W      = 240;
  localparam int LINE_W     = WIN_COLS * PIX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    HOLD
  } state_e;

  // Bank pointers cycle 0 -> 1 -> 2 -> 0; "next" is also the bank that holds row r-2.
  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [1:0] ptr_prev(input logic [1:0] p);
    return (p == 2'd0) ? 2'd2 : p - 2'd1;
  endfunction

endpackage

// File: rtl/cbs_line_bank.sv
// One image line of pixel registers: single write port, 10-pixel combinational read at a base column.
module cbs_line_bank
  import cbs_pkg::*;
#(
  parameter  int IMG_W = 34,
  localparam int AW    = $clog2(IMG_W)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [AW-1:0]     rd_base,
  output logic [LINE_W-1:0] rd_line
);

  logic [PIX_W-1:0] mem_q [IMG_W];
  logic [AW-1:0]    rd_addr;

  // Contents are never cleared; rows 0 and 1 of each frame overwrite them before any read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_line = '0;
    rd_addr = '0;
    for (int k = 0; k < WIN_COLS; k++) begin
      rd_addr = rd_base + AW'(k);
      if (int'(rd_addr) < IMG_W) begin
        rd_line[LINE_W-1-PIX_W*k -: PIX_W] = mem_q[rd_addr];
      end
    end
  end

endmodule

// File: rtl/cbs_window_feeder.sv
// Streaming 3-line buffer that assembles 3x10 pixel windows (stride 8) for the CBS convolution stage.
module cbs_window_feeder
  import cbs_pkg::*;
#(
  parameter int IMG_W = 34,
  parameter int IMG_H = 34
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [WIN_W-1:0]  win_img,
  output logic              frame_done
);

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H);
  localparam int STRIDE_W = $clog2(WIN_STRIDE);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [1:0]        ptr_q, ptr_d;
  logic              pix_ready_q, pix_ready_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [WIN_W-1:0]  win_img_q, win_img_d;

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              trigger;
  logic [COL_W-1:0]  win_base;
  logic [LINE_W-1:0] rd_line [WIN_ROWS];

  assign accept   = pix_valid && pix_ready_q;
  assign col_last = (col_q == COL_W'(IMG_W - 1));
  assign row_last = (row_q == ROW_W'(IMG_H - 1));
  assign win_base = col_q - COL_W'(WIN_COLS - 1);
  assign trigger  = (row_q >= ROW_W'(2)) &&
                    (col_q >= COL_W'(WIN_COLS - 1)) &&
                    (win_base[STRIDE_W-1:0] == '0);

  for (genvar b = 0; b < WIN_ROWS; b++) begin : g_bank
    cbs_line_bank #(
      .IMG_W (IMG_W)
    ) u_bank (
      .clk     (clk),
      .we      (accept && (ptr_q == 2'(b))),
      .wr_addr (col_q),
      .wr_data (pix_data),
      .rd_base (win_base),
      .rd_line (rd_line[b])
    );
  end

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    ptr_d        = ptr_q;
    frame_done_d = 1'b0;
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        ptr_d = ptr_next(ptr_q);
        if (row_last) begin
          row_d        = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  // Current row's last window column is not in its bank yet, so it is bypassed from pix_data.
  always_comb begin
    state_d   = state_q;
    win_img_d = win_img_q;
    unique case (state_q)
      IDLE: state_d = FILL;
      FILL: begin
        if (accept && trigger) begin
          state_d   = HOLD;
          win_img_d = {rd_line[ptr_next(ptr_q)],
                       rd_line[ptr_prev(ptr_q)],
                       rd_line[ptr_q][LINE_W-1:PIX_W],
                       pix_data};
        end
      end
      HOLD: begin
        if (win_valid_q && win_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = IDLE;
    endcase
    pix_ready_d = (state_d == FILL);
    win_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      ptr_q        <= '0;
      pix_ready_q  <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_img_q    <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      ptr_q        <= ptr_d;
      pix_ready_q  <= pix_ready_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      win_img_q    <= win_img_d;
    end
  end

  assign pix_ready  = pix_ready_q;
  assign win_valid  = win_valid_q;
  assign win_img    = win_img_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_cbs_window_feeder.sv
// Scoreboard bench for cbs_window_feeder: the driver queues expected windows, a monitor checks them.
module tb_cbs_window_feeder;

  localparam int IMG_W = 34;
  localparam int IMG_H = 4;

  logic         clk;
  logic         rst_n;
  logic         pix_valid;
  logic         pix_ready;
  logic [7:0]   pix_data;
  logic         win_valid;
  logic         win_ready;
  logic [239:0] win_img;
  logic         frame_done;

  int checks = 0;
  int errors = 0;
  int win_count = 0;
  int done_count = 0;
  logic [239:0] exp_q [$];

  cbs_window_feeder #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_img    (win_img),
    .frame_done (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pixVal(input int r, input int c);
    return 8'((IMG_W * r + c) % 256);
  endfunction

  function automatic logic [239:0] expWin(input int r, input int g);
    logic [239:0] w;
    w = '0;
    for (int l = 0; l < 3; l++) begin
      for (int k = 0; k < 10; k++) begin
        w[239 - 80*l - 8*k -: 8] = pixVal(r - 2 + l, 8*g + k);
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [239:0] act, input logic [239:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one pixel; the expected window is queued at the negedge before its accepting edge.
  task automatic applyStimulus(input int r, input int c, input bit gaps);
    int waited;
    bit trig;
    if (gaps) begin
      for (int i = 0; i < 3 && $urandom_range(0, 1) == 0; i++) begin
        pix_valid = 1'b0;
        @(posedge clk);
        #1;
      end
    end
    pix_valid = 1'b1;
    pix_data  = pixVal(r, c);
    waited    = 0;
    @(negedge clk);
    while (!pix_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!pix_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept timeout: pixel (%0d,%0d) pix_ready got 0 expected 1", r, c);
      pix_valid = 1'b0;
      return;
    end
    trig = (r >= 2) && (c >= 9) && ((c - 9) % 8 == 0);
    if (trig) exp_q.push_back(expWin(r, (c - 9) / 8));
    @(posedge clk);
    #1;
    pix_valid = 1'b0;
    checkOutput("frame_done", frame_done, (r == IMG_H - 1) && (c == IMG_W - 1));
  endtask

  initial begin : monitor
    logic         prev_valid;
    logic [239:0] held;
    prev_valid = 1'b0;
    held       = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        prev_valid = 1'b0;
      end else if (win_valid) begin
        if (!prev_valid) begin
          win_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected window: got %0h expected none", win_img);
          end else begin
            checkOutput("window", win_img, exp_q.pop_front());
          end
          held = win_img;
        end else begin
          checkOutput("win_img stable", win_img, held);
        end
        checkOutput("pix_ready in HOLD", pix_ready, 0);
        prev_valid = 1'b1;
      end else begin
        prev_valid = 1'b0;
      end
      if (frame_done) done_count++;
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : driver
    bit aborted;
    rst_n     = 1'b0;
    pix_valid = 1'b0;
    pix_data  = '0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset pix_ready", pix_ready, 0);
    checkOutput("reset win_valid", win_valid, 0);
    checkOutput("reset win_img", win_img, 0);
    checkOutput("reset frame_done", frame_done, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("pix_ready before first edge", pix_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("pix_ready after release", pix_ready, 1);

    // Frame 1: backpressure on the first window, hand-computed spot checks.
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        if (r == 2 && c == 9) win_ready = 1'b0;
        applyStimulus(r, c, 1'b0);
        if (r == 2 && c == 9) begin
          checkOutput("w0 win_valid", win_valid, 1);
          checkOutput("w0 [239:232]", win_img[239:232], 0);
          checkOutput("w0 [167:160]", win_img[167:160], 9);
          checkOutput("w0 [159:152]", win_img[159:152], 34);
          checkOutput("w0 [79:72]", win_img[79:72], 68);
          checkOutput("w0 [7:0]", win_img[7:0], 77);
          for (int i = 0; i < 5; i++) begin
            checkOutput("bp win_valid", win_valid, 1);
            checkOutput("bp pix_ready", pix_ready, 0);
            @(posedge clk);
            #1;
          end
          win_ready = 1'b1;
        end
        if (r == 3 && c == 33) begin
          checkOutput("w7 [79:72]", win_img[79:72], 126);
          checkOutput("w7 [7:0]", win_img[7:0], 135);
        end
      end
    end

    // Frame 2: random input gaps, same windows expected.
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        applyStimulus(r, c, 1'b1);
      end
    end

    // Frame 3: reset while holding the row-3 g=1 window.
    aborted = 1'b0;
    for (int r = 0; r < IMG_H && !aborted; r++) begin
      for (int c = 0; c < IMG_W && !aborted; c++) begin
        if (r == 3 && c == 17) win_ready = 1'b0;
        applyStimulus(r, c, 1'b0);
        if (r == 3 && c == 17) begin
          checkOutput("pre-reset win_valid", win_valid, 1);
          #2;
          rst_n = 1'b0;
          #1;
          checkOutput("reset-in-HOLD win_valid", win_valid, 0);
          checkOutput("reset-in-HOLD pix_ready", pix_ready, 0);
          checkOutput("reset-in-HOLD win_img", win_img, 0);
          aborted = 1'b1;
        end
      end
    end
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("pix_ready after mid-frame reset", pix_ready, 1);

    // Frame 4: replay from window 0.
    for (int r = 0; r < IMG_H; r++) begin
      for (int c = 0; c < IMG_W; c++) begin
        applyStimulus(r, c, 1'b0);
      end
    end

    repeat (5) @(posedge clk);
    #1;
    checkOutput("pending expected windows", exp_q.size(), 0);
    checkOutput("window count", win_count, 30);
    checkOutput("frame_done pulses", done_count, 3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
